// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared definitions for the SPI command sequencer slice.
// Holds the command opcodes, the sequencer state encoding, default sizing
// values and a small opcode-classification helper used by the decoder.
package spi_cmd_sequencer_pkg;

  localparam int          DEF_NREG     = 8;
  localparam int          DEF_PIXBYTES = 6;
  localparam logic [7:0]  DEF_RDY_BYTE = 8'hFF;

  localparam logic [7:0]  OP_WR    = 8'h80;
  localparam logic [7:0]  OP_RD    = 8'h81;
  localparam logic [7:0]  OP_STRM  = 8'h55;
  localparam logic [7:0]  OP_SRST0 = 8'h40;
  localparam logic [7:0]  OP_SRST1 = 8'h41;

  typedef enum logic [2:0] {
    ST_CMD    = 3'd0,
    ST_RDA    = 3'd1,
    ST_ARG1   = 3'd2,
    ST_ARG2   = 3'd3,
    ST_STREAM = 3'd4
  } seq_state_e;

  // Opcodes that are followed by an address byte and an argument byte.
  function automatic logic is_arg_op(input logic [7:0] op);
    return (op == OP_WR) || (op == OP_STRM) || (op == OP_SRST0) || (op == OP_SRST1);
  endfunction

endpackage

// File: rtl/spi_pix_packer.sv
// Packs consecutive SPI bytes into one pixel word.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   clr          frame abort: drops any partial word, cancels the strobe
//   shift_en     accept byte_dat this cycle
//   byte_dat     received byte
//   pix_vld      1-cycle strobe, pix_dat holds a freshly completed word
//   pix_dat      packed word, first byte of the group in the top byte
module spi_pix_packer #(
  parameter int PIXBYTES = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  shift_en,
  input  logic [7:0]            byte_dat,
  output logic                  pix_vld,
  output logic [8*PIXBYTES-1:0] pix_dat
);

  localparam int              CW       = (PIXBYTES > 1) ? $clog2(PIXBYTES) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(PIXBYTES - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [CW-1:0]   CNT_ZERO = CW'(0);

  logic [CW-1:0]           cnt_r;
  logic [8*PIXBYTES-1:0]   shift_r;
  logic [8*PIXBYTES-1:0]   pix_dat_r;
  logic                    pix_vld_r;

  // Byte counter, shift register and completed-word output register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r     <= CNT_ZERO;
      shift_r   <= {(8*PIXBYTES){1'b0}};
      pix_dat_r <= {(8*PIXBYTES){1'b0}};
      pix_vld_r <= 1'b0;
    end else if (clr) begin
      // The partial word is simply forgotten; pix_dat keeps the last full word.
      cnt_r     <= CNT_ZERO;
      pix_vld_r <= 1'b0;
    end else if (shift_en) begin
      shift_r <= {shift_r[8*PIXBYTES-9:0], byte_dat};
      if (cnt_r == LAST_CNT) begin
        cnt_r     <= CNT_ZERO;
        pix_dat_r <= {shift_r[8*PIXBYTES-9:0], byte_dat};
        pix_vld_r <= 1'b1;
      end else begin
        cnt_r     <= cnt_r + CNT_ONE;
        pix_vld_r <= 1'b0;
      end
    end else begin
      pix_vld_r <= 1'b0;
    end
  end

  assign pix_vld = pix_vld_r;
  assign pix_dat = pix_dat_r;

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Byte-level command sequencer between the SPI slave and the SIFT datapath.
// Decodes command frames, owns the config register file, drives the
// screen-reset level and, in stream mode, packs bytes into pixel words while
// returning datapath result bytes on MISO.
// Ports:
//   clk, rst_n   system clock, synchronous active-low reset
//   css          frame select, low aborts the frame
//   byte_vld     1-cycle strobe for byte_dat
//   byte_dat     received SPI byte
//   ret_dat      datapath result byte returned while streaming
//   tx_dat       byte presented to the SPI slave for the next MISO shift
//   pix_vld      1-cycle strobe, pix_dat valid
//   pix_dat      packed pixel word
//   screen_rst   frame-reset level
//   stream_act   high while streaming
//   cfg_flat     config registers, reg i in [8*i +: 8]
module spi_cmd_sequencer
  import spi_cmd_sequencer_pkg::*;
#(
  parameter int         NREG     = DEF_NREG,
  parameter int         PIXBYTES = DEF_PIXBYTES,
  parameter logic [7:0] RDY_BYTE = DEF_RDY_BYTE
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  css,
  input  logic                  byte_vld,
  input  logic [7:0]            byte_dat,
  input  logic [7:0]            ret_dat,
  output logic [7:0]            tx_dat,
  output logic                  pix_vld,
  output logic [8*PIXBYTES-1:0] pix_dat,
  output logic                  screen_rst,
  output logic                  stream_act,
  output logic [8*NREG-1:0]     cfg_flat
);

  localparam int         AW     = (NREG > 1) ? $clog2(NREG) : 1;
  localparam logic [8:0] NREG_W = 9'(NREG);

  seq_state_e  state_r;
  seq_state_e  state_nxt_s;
  logic [7:0]  opcode_r;
  logic [7:0]  addr_r;
  logic [7:0]  regs_r [NREG];
  logic        screen_rst_r;
  logic [7:0]  tx_dat_r;
  logic [7:0]  rd_val_s;
  logic        wr_addr_ok_s;
  logic        byte_acc_s;
  logic        shift_en_s;

  // A byte only counts when the frame is still selected in the same cycle.
  assign byte_acc_s = css & byte_vld;
  assign shift_en_s = byte_acc_s & (state_r == ST_STREAM);

  // Register-file read port and write-address range check.
  always_comb begin
    rd_val_s     = 8'h00;
    wr_addr_ok_s = 1'b0;
    if ({1'b0, byte_dat} < NREG_W) begin
      rd_val_s = regs_r[byte_dat[AW-1:0]];
    end else begin
      rd_val_s = 8'h00;
    end
    if ({1'b0, addr_r} < NREG_W) begin
      wr_addr_ok_s = 1'b1;
    end else begin
      wr_addr_ok_s = 1'b0;
    end
  end

  // Next-state decode; a deselected frame always returns to CMD.
  always_comb begin
    state_nxt_s = state_r;
    if (!css) begin
      state_nxt_s = ST_CMD;
    end else if (byte_vld) begin
      case (state_r)
        ST_CMD: begin
          if (is_arg_op(byte_dat)) begin
            state_nxt_s = ST_ARG1;
          end else if (byte_dat == OP_RD) begin
            state_nxt_s = ST_RDA;
          end else begin
            state_nxt_s = ST_CMD;
          end
        end
        ST_RDA:    state_nxt_s = ST_CMD;
        ST_ARG1:   state_nxt_s = ST_ARG2;
        ST_ARG2: begin
          if (opcode_r == OP_STRM) begin
            state_nxt_s = ST_STREAM;
          end else begin
            state_nxt_s = ST_CMD;
          end
        end
        ST_STREAM: state_nxt_s = ST_STREAM;
        default:   state_nxt_s = ST_CMD;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_CMD;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Command operands, register file, screen-reset level and MISO byte.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opcode_r     <= 8'h00;
      addr_r       <= 8'h00;
      screen_rst_r <= 1'b0;
      tx_dat_r     <= RDY_BYTE;
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else if (byte_acc_s) begin
      case (state_r)
        ST_CMD: begin
          if (is_arg_op(byte_dat)) begin
            opcode_r <= byte_dat;
          end
          tx_dat_r <= RDY_BYTE;
        end
        ST_RDA: begin
          tx_dat_r <= rd_val_s;
        end
        ST_ARG1: begin
          addr_r   <= byte_dat;
          tx_dat_r <= RDY_BYTE;
        end
        ST_ARG2: begin
          case (opcode_r)
            OP_WR: begin
              if (wr_addr_ok_s) begin
                regs_r[addr_r[AW-1:0]] <= byte_dat;
              end
            end
            OP_SRST0: screen_rst_r <= 1'b0;
            OP_SRST1: screen_rst_r <= 1'b1;
            default:  screen_rst_r <= screen_rst_r;
          endcase
          tx_dat_r <= RDY_BYTE;
        end
        ST_STREAM: begin
          tx_dat_r <= ret_dat;
        end
        default: begin
          tx_dat_r <= RDY_BYTE;
        end
      endcase
    end
  end

  spi_pix_packer #(
    .PIXBYTES (PIXBYTES)
  ) u_packer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (~css),
    .shift_en (shift_en_s),
    .byte_dat (byte_dat),
    .pix_vld  (pix_vld),
    .pix_dat  (pix_dat)
  );

  for (genvar g = 0; g < NREG; g++) begin : g_cfg
    assign cfg_flat[8*g +: 8] = regs_r[g];
  end

  assign tx_dat     = tx_dat_r;
  assign screen_rst = screen_rst_r;
  assign stream_act = (state_r == ST_STREAM);

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Self-checking bench for spi_cmd_sequencer: directed command frames with a
// scoreboard queue of expected pixel words.
module tb_spi_cmd_sequencer;

  logic        clk;
  logic        rst_n;
  logic        css;
  logic        byte_vld;
  logic [7:0]  byte_dat;
  logic [7:0]  ret_dat;
  logic [7:0]  tx_dat;
  logic        pix_vld;
  logic [47:0] pix_dat;
  logic        screen_rst;
  logic        stream_act;
  logic [63:0] cfg_flat;

  int          n_cmp;
  int          n_err;
  logic [47:0] exp_q[$];
  logic [63:0] cfg_exp;

  spi_cmd_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .css        (css),
    .byte_vld   (byte_vld),
    .byte_dat   (byte_dat),
    .ret_dat    (ret_dat),
    .tx_dat     (tx_dat),
    .pix_vld    (pix_vld),
    .pix_dat    (pix_dat),
    .screen_rst (screen_rst),
    .stream_act (stream_act),
    .cfg_flat   (cfg_flat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One byte strobe, then 7 idle cycles; every pix_vld seen is popped and checked.
  task automatic send_byte(input logic [7:0] b);
    logic [47:0] e;
    logic        prev_vld;
    @(negedge clk);
    byte_vld = 1'b1;
    byte_dat = b;
    @(negedge clk);
    byte_vld = 1'b0;
    byte_dat = 8'h00;
    prev_vld = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (k > 0) @(negedge clk);
      if (pix_vld) begin
        n_cmp++;
        if (prev_vld) begin
          n_err++;
          $display("FAIL pix_double: pix_vld high on consecutive cycles");
        end else if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL pix_unexpected: got pix_dat %h, required no pix_vld", pix_dat);
        end else begin
          e = exp_q.pop_front();
          if (pix_dat !== e) begin
            n_err++;
            $display("FAIL pix_dat: got %h required %h", pix_dat, e);
          end
        end
      end
      prev_vld = pix_vld;
    end
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send_byte(a);
    send_byte(b);
    send_byte(c);
  endtask

  task automatic drop_css();
    @(negedge clk);
    css = 1'b0;
    @(negedge clk);
    css = 1'b1;
  endtask

  task automatic check_cfg(input string nm);
    n_cmp++;
    if (cfg_flat !== cfg_exp) begin
      n_err++;
      $display("FAIL %s: cfg_flat got %h required %h", nm, cfg_flat, cfg_exp);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    n_cmp++;
    if (tx_dat !== 8'hFF || pix_vld !== 1'b0 || pix_dat !== 48'h0 ||
        screen_rst !== 1'b0 || stream_act !== 1'b0 || cfg_flat !== 64'h0) begin
      n_err++;
      $display("FAIL %s: got tx=%h vld=%b pix=%h srst=%b act=%b cfg=%h required FF 0 0 0 0 0",
               nm, tx_dat, pix_vld, pix_dat, screen_rst, stream_act, cfg_flat);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;
    css   = 1'b1;
    cfg_exp = 64'h0;
  endtask

  task automatic test_write();
    send3(8'h80, 8'h02, 8'h05);
    cfg_exp[23:16] = 8'h05;
    check_cfg("write_reg2");
    n_cmp++;
    if (tx_dat !== 8'hFF) begin
      n_err++;
      $display("FAIL write_tx: got %h required %h", tx_dat, 8'hFF);
    end
    // Unknown opcode must be ignored without consuming the following frame.
    send_byte(8'h12);
    send3(8'h80, 8'h01, 8'h3C);
    cfg_exp[15:8] = 8'h3C;
    check_cfg("unknown_op_then_write");
  endtask

  task automatic test_read();
    send_byte(8'h81);
    send_byte(8'h02);
    n_cmp++;
    if (tx_dat !== 8'h05) begin
      n_err++;
      $display("FAIL read_tx: got %h required %h", tx_dat, 8'h05);
    end
    send_byte(8'h00);
    n_cmp++;
    if (tx_dat !== 8'hFF) begin
      n_err++;
      $display("FAIL read_after_tx: got %h required %h", tx_dat, 8'hFF);
    end
    send_byte(8'h81);
    send_byte(8'h09);
    n_cmp++;
    if (tx_dat !== 8'h00) begin
      n_err++;
      $display("FAIL read_oob_tx: got %h required %h", tx_dat, 8'h00);
    end
  endtask

  task automatic test_screen_rst();
    send3(8'h41, 8'h00, 8'h00);
    n_cmp++;
    if (screen_rst !== 1'b1) begin
      n_err++;
      $display("FAIL srst_set: got %b required %b", screen_rst, 1'b1);
    end
    send3(8'h40, 8'h00, 8'h00);
    n_cmp++;
    if (screen_rst !== 1'b0) begin
      n_err++;
      $display("FAIL srst_clr: got %b required %b", screen_rst, 1'b0);
    end
  endtask

  task automatic test_stream();
    logic [47:0] pw;
    logic [7:0]  b;
    pw = 48'h0;
    ret_dat = 8'hA5;
    send3(8'h55, 8'h00, 8'h00);
    n_cmp++;
    if (stream_act !== 1'b1) begin
      n_err++;
      $display("FAIL stream_enter: got %b required %b", stream_act, 1'b1);
    end
    for (int i = 1; i <= 12; i++) begin
      b  = 8'(i);
      pw = {pw[39:0], b};
      if (i % 6 == 0) exp_q.push_back(pw);
      send_byte(b);
      if (i == 1) begin
        n_cmp++;
        if (tx_dat !== 8'hA5) begin
          n_err++;
          $display("FAIL stream_tx: got %h required %h", tx_dat, 8'hA5);
        end
      end
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL stream_pix_count: got %0d outstanding words required 0", exp_q.size());
    end
    drop_css();
    n_cmp++;
    if (stream_act !== 1'b0) begin
      n_err++;
      $display("FAIL stream_exit: got %b required %b", stream_act, 1'b0);
    end
  endtask

  task automatic test_abort();
    send3(8'h55, 8'h00, 8'h00);
    send3(8'hB1, 8'hB2, 8'hB3);
    drop_css();
    send3(8'h80, 8'h07, 8'h09);
    cfg_exp[63:56] = 8'h09;
    check_cfg("abort_then_write_reg7");
    n_cmp++;
    if (pix_dat !== 48'h0708090A0B0C) begin
      n_err++;
      $display("FAIL abort_pix_hold: got %h required %h", pix_dat, 48'h0708090A0B0C);
    end
    // Byte arriving in the same cycle as a css drop must be discarded.
    @(negedge clk);
    css      = 1'b0;
    byte_vld = 1'b1;
    byte_dat = 8'h80;
    @(negedge clk);
    css      = 1'b1;
    byte_vld = 1'b0;
    byte_dat = 8'h00;
    send_byte(8'h03);
    send_byte(8'h22);
    check_cfg("css_wins_drop");
  endtask

  task automatic test_bad_addr_and_reset();
    send3(8'h80, 8'h0A, 8'h33);
    check_cfg("bad_addr");
    send3(8'h41, 8'h00, 8'h00);
    send3(8'h55, 8'h00, 8'h00);
    send_byte(8'hC1);
    send_byte(8'hC2);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_vals("reset_mid_stream");
    rst_n = 1'b1;
    cfg_exp = 64'h0;
    send3(8'h80, 8'h05, 8'h77);
    cfg_exp[47:40] = 8'h77;
    check_cfg("after_reset_write");
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL final_queue: got %0d outstanding words required 0", exp_q.size());
    end
  endtask

  initial begin
    n_cmp    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    css      = 1'b0;
    byte_vld = 1'b0;
    byte_dat = 8'h00;
    ret_dat  = 8'h00;
    cfg_exp  = 64'h0;
    test_reset();
    test_write();
    test_read();
    test_screen_rst();
    test_stream();
    test_abort();
    test_bad_addr_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
